// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL bring-up / reset sequencer.
// The state encoding is also driven onto the debug "state" port.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// STAGES-deep single-bit synchronizer for asynchronous level inputs.
// Also usable for buttons, UART RX, and similar signals.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings up the EHXPLLL on the reference clock and holds sys_reset until lock
// has been stable for a window; restarts on lock loss or acquisition timeout.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES         = 2,
  parameter int RETRY_W             = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic               locked,
  output logic [1:0]         state,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that saw lock_s high is the first of the stable window.
  localparam logic [CNT_W-1:0] STAB_LAST =
    CNT_W'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);

  seq_state_e         r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_pll_rst, r_sys_reset, r_locked;
  logic               w_lock_s, w_retry_inc;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  always_comb begin
    w_next      = r_state;
    w_retry_inc = 1'b0;
    case (r_state)
      PLL_RST:   if (r_cnt == RST_LAST) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (w_lock_s) w_next = STABILIZE;
        else if (r_cnt == TMO_LAST) begin
          w_next      = PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      STABILIZE: begin
        if (!w_lock_s)               w_next = WAIT_LOCK;
        else if (r_cnt >= STAB_LAST) w_next = RUN;
      end
      RUN: begin
        if (!w_lock_s) begin
          w_next      = PLL_RST;
          w_retry_inc = 1'b1;
        end
      end
      default:   w_next = PLL_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_reset <= 1'b1;
      r_locked    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_cnt <= '0;
      else if (r_state != RUN) r_cnt <= r_cnt + CNT_W'(1);
      if (w_retry_inc && (r_retry != '1)) r_retry <= r_retry + RETRY_W'(1);
      // Outputs decoded from the next state so they change with the state register.
      r_pll_rst   <= (w_next == PLL_RST);
      r_sys_reset <= (w_next != RUN);
      r_locked    <= (w_next == RUN);
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_reset   = r_sys_reset;
  assign locked      = r_locked;
  assign state       = r_state;
  assign retry_count = r_retry;

endmodule
